adc_ring_ctrl: RTL and testbench

Ring-buffer controller sitting directly in front of, and behind, the 12x16 two-port ADC sample SRAM. Accepts one 12-bit ADC conversion per S_VALID strobe, writes it into the SRAM as a 16-entry circular buffer, and drains the buffer in order to a downstream valid/ready consumer. It tracks occupancy and reports a sticky overflow when the ADC outruns the consumer.

---
 rtl/adc_ring_pkg.sv | 14 +
 rtl/adc_ring_ctrl.sv | 136 +++++++++++++
 tb/tb_adc_ring_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ring_pkg.sv
// Shared constants and read-side state encoding for the ADC sample ring controller.
package adc_ring_pkg;

    localparam int unsigned ADC_DW    = 12;
    localparam int unsigned ADC_AW    = 4;
    localparam int unsigned ADC_DEPTH = 1 << ADC_AW;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } rd_state_e;

endpackage

// File: rtl/adc_ring_ctrl.sv
// Circular-buffer controller between the ADC, the 12x16 two-port sample SRAM and a valid/ready consumer.
// Define ADC_RING_OVWR_EN to make a sample arriving on a full buffer overwrite the oldest entry.
module adc_ring_ctrl
    import adc_ring_pkg::*;
#(
    parameter int unsigned DW = ADC_DW,
    parameter int unsigned AW = ADC_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    output logic [DW-1:0] M_DATA,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [AW:0]   OCC,
    output logic          OVERFLOW,
    input  logic          CLR_OVF,
    output logic [AW-1:0] WADDR,
    output logic [DW-1:0] WD,
    output logic          WEN,
    output logic [AW-1:0] RADDR,
    input  logic [DW-1:0] RD
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    rd_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          ovf_q, ovf_d;

    logic full, fetch_ok, fetch, wr_new, wr_ovwr;

    assign full = (occ_q == FULL_CNT);
    // A sample landing on a full buffer targets rd_ptr, so the fetch waits one cycle.
    assign fetch_ok = (occ_q != '0) && !(full && S_VALID);
    assign wr_new   = S_VALID && !full;
`ifdef ADC_RING_OVWR_EN
    assign wr_ovwr = S_VALID && full;
`else
    assign wr_ovwr = 1'b0;
`endif

    assign WEN      = !RST && (wr_new || wr_ovwr);
    assign WADDR    = wr_ptr_q;
    assign WD       = S_DATA;
    assign RADDR    = rd_ptr_q;
    assign M_DATA   = m_data_q;
    assign M_VALID  = m_valid_q;
    assign OCC      = occ_q;
    assign OVERFLOW = ovf_q;

    always_comb begin
        state_d   = state_q;
        fetch     = 1'b0;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        unique case (state_q)
            RD_EMPTY: begin
                m_valid_d = 1'b0;
                if (fetch_ok) begin
                    fetch   = 1'b1;
                    state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                m_data_d  = RD;
                m_valid_d = 1'b1;
                state_d   = RD_VALID;
            end
            RD_VALID: begin
                if (M_READY) begin
                    m_valid_d = 1'b0;
                    if (fetch_ok) begin
                        fetch   = 1'b1;
                        state_d = RD_FETCH;
                    end else begin
                        state_d = RD_EMPTY;
                    end
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = RD_EMPTY;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        if (wr_new || wr_ovwr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fetch || wr_ovwr) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_new && !fetch) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (fetch && !wr_new) begin
            occ_d = occ_q - (AW+1)'(1);
        end
        if (S_VALID && full) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RD_EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adc_ring_ctrl.sv
// Directed bench for adc_ring_ctrl with a behavioural two-port SRAM model.
// Honours ADC_RING_OVWR_EN so the same bench covers both full-buffer policies.
module tb_adc_ring_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] S_DATA = '0;
    logic        S_VALID = 1'b0;
    logic [11:0] M_DATA;
    logic        M_VALID;
    logic        M_READY = 1'b0;
    logic [4:0]  OCC;
    logic        OVERFLOW;
    logic        CLR_OVF = 1'b0;
    logic [3:0]  WADDR;
    logic [11:0] WD;
    logic        WEN;
    logic [3:0]  RADDR;
    logic [11:0] RD;

    adc_ring_ctrl #(.DW(12), .AW(4)) dut (
        .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID),
        .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
        .OCC(OCC), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF),
        .WADDR(WADDR), .WD(WD), .WEN(WEN), .RADDR(RADDR), .RD(RD)
    );

    always #5 CLK = ~CLK;

    logic [11:0] mem [16];
    logic [11:0] rd_q = '0;
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge CLK) begin
        if (WEN) mem[WADDR] <= WD;
        rd_q <= mem[RADDR];
    end
    assign RD = rd_q;

    int          cycle = 0;
    logic [11:0] got[$];
    int          got_cyc[$];
    logic [11:0] exp_q[$];
    int unsigned max_occ = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge CLK) cycle <= cycle + 1;

    always @(negedge CLK) begin
        if (!RST && M_VALID && M_READY) begin
            got.push_back(M_DATA);
            got_cyc.push_back(cycle);
        end
        if (int'(OCC) > max_occ) max_occ = int'(OCC);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_got(input string tag, input int n);
        int budget = 0;
        while (got.size() < n && budget < 200) begin
            cyc();
            budget++;
        end
        check_val({tag, "_count"}, got.size(), n);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check_val({tag, "_data"}, {20'h0, got[i]}, {20'h0, exp_q[i]});
    endtask

    task automatic clear_got();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int bad_gap;

        // Reset, with S_VALID high to confirm RST masks WEN.
        RST = 1'b1; S_VALID = 1'b1; S_DATA = 12'h777;
        cyc(); cyc();
        #1;
        check_val("rst_mvalid", M_VALID, 0);
        check_val("rst_mdata", M_DATA, 0);
        check_val("rst_occ", OCC, 0);
        check_val("rst_ovf", OVERFLOW, 0);
        check_val("rst_wen", WEN, 0);

        // Single sample: written at k, fetched k+1, valid after k+2.
        RST = 1'b0; S_DATA = 12'h5A3; M_READY = 1'b1;
        #1;
        check_val("one_wen", WEN, 1);
        check_val("one_waddr", WADDR, 0);
        check_val("one_wd", WD, 12'h5A3);
        cyc(); S_VALID = 1'b0;
        check_val("one_occ1", OCC, 1);
        check_val("one_mv_k", M_VALID, 0);
        cyc();
        check_val("one_occ0", OCC, 0);
        check_val("one_mv_k1", M_VALID, 0);
        cyc();
        check_val("one_mv_k2", M_VALID, 1);
        check_val("one_mdata", M_DATA, 12'h5A3);
        cyc();
        check_val("one_mv_drop", M_VALID, 0);

        // 17 samples with the consumer stalled: the first is held in M_DATA, 16 fill the SRAM.
        M_READY = 1'b0;
        for (int i = 0; i < 17; i++) begin
            S_VALID = 1'b1; S_DATA = 12'(i);
            cyc();
        end
        check_val("fill_occ", OCC, 16);
        check_val("fill_ovf", OVERFLOW, 0);
        check_val("fill_mvalid", M_VALID, 1);
        check_val("fill_mdata", M_DATA, 0);

        // Sample on a full buffer.
        S_DATA = 12'hABC;
        #1;
`ifdef ADC_RING_OVWR_EN
        check_val("full_wen", WEN, 1);
`else
        check_val("full_wen", WEN, 0);
`endif
        cyc();
        S_VALID = 1'b0;
        check_val("full_ovf", OVERFLOW, 1);
        check_val("full_occ", OCC, 16);

        CLR_OVF = 1'b1;
        cyc();
        check_val("clr_ovf", OVERFLOW, 0);
        S_VALID = 1'b1; S_DATA = 12'hDEF;
        cyc();
        check_val("clr_vs_set", OVERFLOW, 1);
        S_VALID = 1'b0; CLR_OVF = 1'b0;

        // Drain: one sample every two cycles, in write order.
        clear_got();
        exp_q.push_back(12'h000);
`ifdef ADC_RING_OVWR_EN
        for (int i = 3; i <= 16; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'hABC);
        exp_q.push_back(12'hDEF);
`else
        for (int i = 1; i <= 16; i++) exp_q.push_back(12'(i));
`endif
        M_READY = 1'b1;
        wait_got("drain", 17);
        bad_gap = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 2) bad_gap++;
        check_val("drain_gap", bad_gap, 0);
        check_val("drain_occ", OCC, 0);
        check_val("drain_mvalid", M_VALID, 0);

        // Collision: full buffer, new sample and handshake on the same edge.
        CLR_OVF = 1'b1; M_READY = 1'b0;
        cyc();
        CLR_OVF = 1'b0;
        for (int i = 0; i < 17; i++) begin
            S_VALID = 1'b1; S_DATA = 12'h100 + 12'(i);
            cyc();
        end
        check_val("col_pre_occ", OCC, 16);
        clear_got();
        S_DATA = 12'h1AB; M_READY = 1'b1;
        cyc();
        S_VALID = 1'b0;
        check_val("col_mvalid", M_VALID, 0);
        check_val("col_occ", OCC, 16);
        check_val("col_ovf", OVERFLOW, 1);
        exp_q.push_back(12'h100);
`ifdef ADC_RING_OVWR_EN
        check_val("col_raddr", RADDR, 6);
        for (int i = 2; i <= 16; i++) exp_q.push_back(12'h100 + 12'(i));
        exp_q.push_back(12'h1AB);
`else
        check_val("col_raddr", RADDR, 3);
        for (int i = 1; i <= 16; i++) exp_q.push_back(12'h100 + 12'(i));
`endif
        wait_got("col", 17);
        check_val("col_end_occ", OCC, 0);

        // Trickle across the pointer wrap: a sample every third cycle, consumer always ready.
        clear_got();
        max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(12'h200 + 12'(i));
            S_VALID = 1'b1; S_DATA = 12'h200 + 12'(i);
            cyc();
            S_VALID = 1'b0;
            cyc(); cyc();
        end
        wait_got("trickle", 20);
        check_val("trickle_max_occ", max_occ, 1);

        // Reset while holding a valid sample with five more queued.
        M_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            S_VALID = 1'b1; S_DATA = 12'h300 + 12'(i);
            cyc();
        end
        S_VALID = 1'b0;
        cyc();
        check_val("pre_rst_occ", OCC, 5);
        check_val("pre_rst_mvalid", M_VALID, 1);
        check_val("pre_rst_mdata", M_DATA, 12'h300);
        check_val("pre_rst_ovf", OVERFLOW, 1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check_val("mid_rst_mvalid", M_VALID, 0);
        check_val("mid_rst_mdata", M_DATA, 0);
        check_val("mid_rst_occ", OCC, 0);
        check_val("mid_rst_ovf", OVERFLOW, 0);
        check_val("mid_rst_raddr", RADDR, 0);
        check_val("mid_rst_waddr", WADDR, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
